spi_slave_sync: RTL

- Parametrised successor to the team's SPI register slave, generalised in address width, data width and SPI mode (CPOL/CPHA).
- Runs entirely in the system clock domain: SCLK/CS/MOSI are oversampled through 2-FF synchronisers, not used as clocks.
- Decodes a command frame (R/W bit, address, data) and drives a single-cycle write strobe or a read request/response handshake to the register file.
- Adds abort detection and read-timeout error flags, which the previous generation lacks.

---
 rtl/spi_slave_sync.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI register slave that runs entirely in the system clock
// domain. SCLK, CS and MOSI are oversampled through 2-FF synchronisers, and a
// third flop on SCLK/CS supplies edge detection. A frame is
// {rw, adr[ADR_W-1:0], data[DATA_W-1:0]}, MSB first, with rw=1 meaning read.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   sclk, cs, mosi    asynchronous SPI pins (cs active-low)
//   miso, miso_oe     SPI data out and its tristate enable
//   adr               address captured from the last complete address field
//   wr_data           write data from the last complete write frame
//   wr_strobe         one-cycle pulse: adr/wr_data hold a write
//   rd_req            one-cycle pulse: read of adr requested
//   rd_valid, rd_data read response from the register file
//   rd_err            sticky: read response missed its deadline
//   frame_err         one-cycle pulse: CS deasserted mid-frame
//   busy              a frame is in progress
//
// Handshake: wr_strobe and rd_req are single-cycle pulses with no back-pressure.
// A response is accepted when rd_valid is high in any cycle after rd_req and
// before the MISO shift register loads; at the load cycle itself rd_valid is
// forwarded straight into the shift register. Later responses are dropped.
module spi_slave_sync #(
    parameter int ADR_W  = 8,
    parameter int DATA_W = 32,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_strobe,
    output logic              rd_req,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int FRAME = 1 + ADR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam int MAX_W = (ADR_W > DATA_W) ? ADR_W : DATA_W;
    localparam int SH_W  = (MAX_W < 2) ? 2 : MAX_W;
    // bit_cnt counts sample edges seen in the frame.
    localparam logic [CNT_W-1:0] ADR_END    = CNT_W'(ADR_W);      // before last address sample
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(ADR_W + 1);  // address field complete
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME - 1);  // before last data sample
    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME);
    localparam logic             SCLK_IDLE  = (CPOL != 0);

    typedef enum logic [2:0] {
        S_WAIT_CS, S_IDLE, S_CMD, S_ADR, S_DATA, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic sclk_meta_q, sclk_sync_q, sclk_dly_q, sclk_meta_d, sclk_sync_d, sclk_dly_d;
    logic cs_meta_q, cs_sync_q, cs_dly_q, cs_meta_d, cs_sync_d, cs_dly_d;
    logic mosi_meta_q, mosi_sync_q, mosi_meta_d, mosi_sync_d;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              rw_q, rw_d;
    logic [SH_W-2:0]   shift_in_q, shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] rd_lat_q, rd_lat_d;
    logic              rd_have_q, rd_have_d;
    logic              rd_win_q, rd_win_d;
    logic              adr_done_q, adr_done_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_err_q, rd_err_d;
    logic              frame_err_q, frame_err_d;

    logic              sclk_rise, sclk_fall, lead_e, trail_e, sample_e, shift_e;
    logic              cs_rise, cs_fall, last_data, abort, load_now;
    logic [SH_W-1:0]   shift_nx;
    logic [CNT_W-1:0]  cnt_inc;

    // Edge qualification, shared by the FSM and the datapath.
    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_dly_d  = sclk_sync_q;
        cs_meta_d   = cs;
        cs_sync_d   = cs_meta_q;
        cs_dly_d    = cs_sync_q;
        mosi_meta_d = mosi;
        mosi_sync_d = mosi_meta_q;

        sclk_rise = sclk_sync_q & ~sclk_dly_q;
        sclk_fall = ~sclk_sync_q & sclk_dly_q;
        lead_e    = (CPOL == 0) ? sclk_rise : sclk_fall;
        trail_e   = (CPOL == 0) ? sclk_fall : sclk_rise;
        sample_e  = (CPHA == 0) ? lead_e : trail_e;
        shift_e   = (CPHA == 0) ? trail_e : lead_e;
        cs_rise   = cs_sync_q & ~cs_dly_q;
        cs_fall   = ~cs_sync_q & cs_dly_q;

        shift_nx  = {shift_in_q, mosi_sync_q};
        cnt_inc   = (bit_cnt_q == FRAME_CNT) ? bit_cnt_q : bit_cnt_q + 1'b1;
        last_data = (bit_cnt_q == LAST_CNT);
        // A final sample edge coinciding with CS rising completes the frame.
        abort     = cs_rise && ((state_q == S_CMD) || (state_q == S_ADR) ||
                                ((state_q == S_DATA) && !(sample_e && last_data)));
        // CPHA=1 loads on the first data shift edge; CPHA=0 has no such edge
        // before the first data sample, so it loads one clock after the address.
        load_now  = rw_q && (state_q == S_DATA) &&
                    ((CPHA != 0) ? (shift_e && (bit_cnt_q == DATA_START)) : adr_done_q);
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_WAIT_CS;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_CS: if (cs_sync_q) state_d = S_IDLE;
            S_IDLE:    if (cs_fall) state_d = S_CMD;
            S_CMD:     if (cs_rise) state_d = S_IDLE;
                       else if (sample_e) state_d = S_ADR;
            S_ADR:     if (cs_rise) state_d = S_IDLE;
                       else if (sample_e && (bit_cnt_q == ADR_END)) state_d = S_DATA;
            S_DATA:    if (sample_e && last_data) state_d = S_DONE;
                       else if (cs_rise) state_d = S_IDLE;
            // Level test so a CS rise that coincided with the last bit still exits.
            S_DONE:    if (cs_sync_q) state_d = S_IDLE;
            default:   state_d = S_WAIT_CS;
        endcase
    end

    // FSM: outputs. WAIT_CS is not a frame, so busy stays low out of reset.
    always_comb begin
        busy    = (state_q == S_CMD) || (state_q == S_ADR) ||
                  (state_q == S_DATA) || (state_q == S_DONE);
        miso_oe = busy && !cs_sync_q;
    end

    // Datapath next-state
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rw_d        = rw_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rd_lat_d    = rd_lat_q;
        rd_have_d   = rd_have_q;
        rd_win_d    = rd_win_q;
        adr_done_d  = 1'b0;
        adr_d       = adr_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = 1'b0;
        rd_req_d    = 1'b0;
        rd_err_d    = rd_err_q;
        frame_err_d = abort;

        if (rd_win_q && rd_valid) begin
            rd_have_d = 1'b1;
            rd_lat_d  = rd_data;
        end

        case (state_q)
            S_IDLE: begin
                shift_out_d = '0;
                rd_win_d    = 1'b0;
                rd_have_d   = 1'b0;
                if (cs_fall) begin
                    rd_err_d  = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            S_CMD: if (!cs_rise && sample_e) begin
                rw_d      = mosi_sync_q;
                bit_cnt_d = cnt_inc;
            end
            S_ADR: if (!cs_rise && sample_e) begin
                shift_in_d = shift_nx[SH_W-2:0];
                bit_cnt_d  = cnt_inc;
                if (bit_cnt_q == ADR_END) begin
                    adr_d      = shift_nx[ADR_W-1:0];
                    rd_req_d   = rw_q;
                    rd_win_d   = rw_q;
                    adr_done_d = 1'b1;
                end
            end
            S_DATA: begin
                if (sample_e) begin
                    shift_in_d = shift_nx[SH_W-2:0];
                    bit_cnt_d  = cnt_inc;
                    if (last_data && !rw_q) begin
                        wr_data_d   = shift_nx[DATA_W-1:0];
                        wr_strobe_d = 1'b1;
                    end
                end
                if (load_now) begin
                    rd_win_d  = 1'b0;
                    rd_have_d = 1'b0;
                    if (rd_have_q) begin
                        shift_out_d = rd_lat_q;
                    end else if (rd_win_q && rd_valid) begin
                        shift_out_d = rd_data;
                    end else begin
                        shift_out_d = '0;
                        rd_err_d    = 1'b1;
                    end
                end else if (shift_e && (bit_cnt_q > DATA_START)) begin
                    // Only shift edges after the first data sample advance MISO.
                    shift_out_d = shift_out_q << 1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_meta_q <= SCLK_IDLE;
            sclk_sync_q <= SCLK_IDLE;
            sclk_dly_q  <= SCLK_IDLE;
            // CS flops clear low so WAIT_CS needs a genuinely observed CS high.
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_dly_q    <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            rd_lat_q    <= '0;
            rd_have_q   <= 1'b0;
            rd_win_q    <= 1'b0;
            adr_done_q  <= 1'b0;
            adr_q       <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_dly_q    <= cs_dly_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rd_lat_q    <= rd_lat_d;
            rd_have_q   <= rd_have_d;
            rd_win_q    <= rd_win_d;
            adr_done_q  <= adr_done_d;
            adr_q       <= adr_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            rd_req_q    <= rd_req_d;
            rd_err_q    <= rd_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = shift_out_q[DATA_W-1];
    assign adr       = adr_q;
    assign wr_data   = wr_data_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_req    = rd_req_q;
    assign rd_err    = rd_err_q;
    assign frame_err = frame_err_q;
endmodule
